// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver, LSB first, idle-high line. The serial input
//            is synchronised, a falling edge starts a frame, the start bit is
//            re-checked at its midpoint and data/stop bits are sampled one bit
//            period apart from there.
// Ports    : clock_50M  - system clock, rising edge
//            n_rst      - asynchronous active-low reset
//            rx         - asynchronous serial line
//            read       - consumer acknowledge, clears data_ready/overrun
//            rx_data    - last correctly framed byte
//            valid      - 1-cycle pulse when rx_data is updated
//            data_ready - level, set by a good frame, cleared by read
//            frame_err  - 1-cycle pulse when the stop bit samples low
//            overrun    - sticky, good frame arrived while data_ready=1
//            busy       - receiver is not idle
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter logic [8:0] CLKS_PER_BIT = 9'd434,
  parameter logic [8:0] HALF_BIT     = 9'd217
) (
  input  logic       clock_50M,
  input  logic       n_rst,
  input  logic       rx,
  input  logic       read,
  output logic [7:0] rx_data,
  output logic       valid,
  output logic       data_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [8:0] c_bit_last  = CLKS_PER_BIT - 9'd1;
  localparam logic [8:0] c_half_last = HALF_BIT - 9'd1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t     r_state;
  logic       r_rx_meta;
  logic       r_rx_s;
  logic       r_rx_d;
  logic [8:0] r_count;
  logic [2:0] r_index;
  logic [7:0] r_shift;

  // Two-flop synchroniser plus one delay stage for edge detection. Reset to
  // the idle level so that leaving reset never looks like a start edge.
  always_ff @(posedge clock_50M or negedge n_rst) begin
    if (!n_rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_d    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_rx_d    <= r_rx_s;
    end
  end

  always_ff @(posedge clock_50M or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= S_IDLE;
      r_count    <= 9'd0;
      r_index    <= 3'd0;
      r_shift    <= 8'h00;
      rx_data    <= 8'h00;
      valid      <= 1'b0;
      data_ready <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;

      // overrun can only be set while data_ready is high, so clearing both
      // on any read is harmless when data_ready is already low. A frame
      // completing in this same cycle overrides the clear below.
      if (read) begin
        data_ready <= 1'b0;
        overrun    <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          // Edge, not level: a line held low (break) cannot restart a frame
          // until it has gone high for at least one cycle.
          if (r_rx_d && !r_rx_s) begin
            r_count <= 9'd0;
            r_index <= 3'd0;
            r_state <= S_START;
          end
        end

        S_START: begin
          if (r_count == c_half_last) begin
            r_count <= 9'd0;
            r_state <= r_rx_s ? S_IDLE : S_DATA;
          end else begin
            r_count <= r_count + 9'd1;
          end
        end

        S_DATA: begin
          if (r_count == c_bit_last) begin
            r_shift <= {r_rx_s, r_shift[7:1]};
            r_count <= 9'd0;
            r_index <= r_index + 3'd1;
            if (r_index == 3'd7) begin
              r_state <= S_STOP;
            end
          end else begin
            r_count <= r_count + 9'd1;
          end
        end

        S_STOP: begin
          if (r_count == c_bit_last) begin
            r_count <= 9'd0;
            r_state <= S_IDLE;
            if (r_rx_s) begin
              rx_data    <= r_shift;
              valid      <= 1'b1;
              data_ready <= 1'b1;
              if (data_ready && !read) begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            r_count <= r_count + 9'd1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Self-checking bench for uart_rx. Frames are generated bit by bit
//            on the serial line; expected rx_data / data_ready / overrun come
//            from a byte-level model of the consumer handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int c_bit = 434;

  logic       clock_50M;
  logic       n_rst;
  logic       rx;
  logic       read;
  logic [7:0] rx_data;
  logic       valid;
  logic       data_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int total = 0;
  int bad   = 0;

  // Observation counters, written only by the monitor below.
  int         valid_cnt   = 0;
  int         ferr_cnt    = 0;
  int         both_cnt    = 0;
  int         busy_cycles = 0;
  logic [7:0] got_q[$];

  // Byte-level model of the receiver's consumer-facing state.
  logic [7:0] m_data  = 8'h00;
  logic       m_ready = 1'b0;
  logic       m_ovr   = 1'b0;

  uart_rx dut (
    .clock_50M  (clock_50M),
    .n_rst      (n_rst),
    .rx         (rx),
    .read       (read),
    .rx_data    (rx_data),
    .valid      (valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  initial clock_50M = 1'b0;
  always #10 clock_50M = ~clock_50M;

  always @(negedge clock_50M) begin
    if (valid) begin
      valid_cnt = valid_cnt + 1;
      got_q.push_back(rx_data);
    end
    if (frame_err) ferr_cnt = ferr_cnt + 1;
    if (valid && frame_err) both_cnt = both_cnt + 1;
    if (busy) busy_cycles = busy_cycles + 1;
  end

  task automatic m_good(input logic [7:0] b);
    if (m_ready) m_ovr = 1'b1;
    m_data  = b;
    m_ready = 1'b1;
  endtask

  task automatic m_read();
    m_ready = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock_50M);
  endtask

  task automatic pulse_read();
    @(negedge clock_50M);
    read = 1'b1;
    @(negedge clock_50M);
    read = 1'b0;
  endtask

  // Drives start, 8 data bits LSB first and the stop bit; the line is left
  // at the stop level. Optionally pulses read during data bit 3.
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input int period, input bit rd_mid);
    rx = 1'b0;
    wait_cycles(period);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (rd_mid && i == 3) begin
        pulse_read();
        wait_cycles(period - 2);
      end else begin
        wait_cycles(period);
      end
    end
    rx = stop;
    wait_cycles(period);
  endtask

  task automatic test_reset();
    rx = 1'b1; read = 1'b0; n_rst = 1'b0;
    wait_cycles(5);
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data got=%h want=00", rx_data); end
    total++; if ({valid, data_ready, frame_err, overrun, busy} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b want=00000", {valid, data_ready, frame_err, overrun, busy}); end
    n_rst = 1'b1;
    wait_cycles(5);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy got=%b want=0", busy); end
  endtask

  task automatic test_single();
    int v0 = valid_cnt, f0 = ferr_cnt;
    send_frame(8'hA5, 1'b1, c_bit, 1'b0);
    rx = 1'b1; wait_cycles(5);
    m_good(8'hA5);
    total++; if (valid_cnt - v0 !== 1) begin bad++; $display("FAIL a5_valid_pulses got=%0d want=1", valid_cnt - v0); end
    total++; if (ferr_cnt - f0 !== 0) begin bad++; $display("FAIL a5_frame_err got=%0d want=0", ferr_cnt - f0); end
    total++; if (rx_data !== m_data) begin bad++; $display("FAIL a5_rx_data got=%h want=%h", rx_data, m_data); end
    total++; if ({data_ready, overrun} !== {m_ready, m_ovr}) begin bad++; $display("FAIL a5_ready_ovr got=%b want=%b", {data_ready, overrun}, {m_ready, m_ovr}); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL a5_busy got=%b want=0", busy); end
  endtask

  task automatic test_overrun();
    pulse_read(); m_read(); wait_cycles(2);
    total++; if (data_ready !== 1'b0) begin bad++; $display("FAIL ovr_pre_read got=%b want=0", data_ready); end
    send_frame(8'h3C, 1'b1, c_bit, 1'b0); rx = 1'b1; wait_cycles(5); m_good(8'h3C);
    total++; if ({overrun, rx_data} !== {m_ovr, m_data}) begin bad++; $display("FAIL ovr_first got=%b/%h want=%b/%h", overrun, rx_data, m_ovr, m_data); end
    send_frame(8'hC3, 1'b1, c_bit, 1'b0); rx = 1'b1; wait_cycles(5); m_good(8'hC3);
    total++; if ({overrun, data_ready, rx_data} !== {m_ovr, m_ready, m_data}) begin bad++; $display("FAIL ovr_second got=%b%b/%h want=%b%b/%h", overrun, data_ready, rx_data, m_ovr, m_ready, m_data); end
    pulse_read(); m_read(); wait_cycles(2);
    total++; if ({data_ready, overrun} !== {m_ready, m_ovr}) begin bad++; $display("FAIL ovr_cleared got=%b want=%b", {data_ready, overrun}, {m_ready, m_ovr}); end
    pulse_read(); wait_cycles(2);
    total++; if ({data_ready, overrun, rx_data} !== {m_ready, m_ovr, m_data}) begin bad++; $display("FAIL idle_read got=%b%b/%h want=%b%b/%h", data_ready, overrun, rx_data, m_ready, m_ovr, m_data); end
  endtask

  task automatic test_frame_err();
    int v0 = valid_cnt, f0 = ferr_cnt, b0;
    send_frame(8'h55, 1'b0, c_bit, 1'b0);
    b0 = busy_cycles;
    wait_cycles(2000);
    total++; if (busy_cycles - b0 !== 0) begin bad++; $display("FAIL break_busy got=%0d want=0", busy_cycles - b0); end
    rx = 1'b1; wait_cycles(10);
    total++; if (ferr_cnt - f0 !== 1) begin bad++; $display("FAIL ferr_pulses got=%0d want=1", ferr_cnt - f0); end
    total++; if (valid_cnt - v0 !== 0) begin bad++; $display("FAIL ferr_valid got=%0d want=0", valid_cnt - v0); end
    total++; if ({data_ready, rx_data} !== {m_ready, m_data}) begin bad++; $display("FAIL ferr_hold got=%b/%h want=%b/%h", data_ready, rx_data, m_ready, m_data); end
    send_frame(8'h0F, 1'b1, c_bit, 1'b0); rx = 1'b1; wait_cycles(5); m_good(8'h0F);
    total++; if (valid_cnt - v0 !== 1 || rx_data !== m_data) begin bad++; $display("FAIL after_break got=%0d/%h want=1/%h", valid_cnt - v0, rx_data, m_data); end
  endtask

  task automatic test_glitch();
    int v0 = valid_cnt, f0 = ferr_cnt, b0 = busy_cycles;
    rx = 1'b0; wait_cycles(100);
    rx = 1'b1; wait_cycles(400);
    total++; if (busy_cycles - b0 < 1 || busy_cycles - b0 > 225) begin bad++; $display("FAIL glitch_busy got=%0d want=1..225", busy_cycles - b0); end
    total++; if (valid_cnt - v0 !== 0 || ferr_cnt - f0 !== 0) begin bad++; $display("FAIL glitch_pulses got=%0d/%0d want=0/0", valid_cnt - v0, ferr_cnt - f0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_idle got=%b want=0", busy); end
  endtask

  task automatic test_mid_reset();
    int v0 = valid_cnt, f0 = ferr_cnt;
    rx = 1'b0; wait_cycles(c_bit);
    rx = 1'b1; wait_cycles(4 * c_bit + c_bit / 2);
    #3 n_rst = 1'b0;
    #2;
    total++; if ({rx_data, valid, data_ready, frame_err, overrun, busy} !== 13'h0) begin bad++; $display("FAIL midreset_async got=%h/%b want=00/00000", rx_data, {valid, data_ready, frame_err, overrun, busy}); end
    wait_cycles(10);
    n_rst = 1'b1;
    m_data = 8'h00; m_ready = 1'b0; m_ovr = 1'b0;
    wait_cycles(20);
    total++; if (valid_cnt - v0 !== 0 || ferr_cnt - f0 !== 0 || busy !== 1'b0) begin bad++; $display("FAIL midreset_abort got=%0d/%0d/%b want=0/0/0", valid_cnt - v0, ferr_cnt - f0, busy); end
    send_frame(8'h81, 1'b1, c_bit, 1'b0); rx = 1'b1; wait_cycles(5); m_good(8'h81);
    total++; if ({rx_data, data_ready, overrun} !== {m_data, m_ready, m_ovr}) begin bad++; $display("FAIL midreset_next got=%h%b%b want=%h%b%b", rx_data, data_ready, overrun, m_data, m_ready, m_ovr); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    int v0 = valid_cnt, f0 = ferr_cnt, q0 = got_q.size();
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h5A;
    for (int i = 0; i < 3; i++) send_frame(bytes[i], 1'b1, 435, 1'b0);
    rx = 1'b1; wait_cycles(10);
    for (int i = 0; i < 3; i++) m_good(bytes[i]);
    total++; if (valid_cnt - v0 !== 3 || ferr_cnt - f0 !== 0) begin bad++; $display("FAIL b2b_counts got=%0d/%0d want=3/0", valid_cnt - v0, ferr_cnt - f0); end
    for (int i = 0; i < 3; i++) begin
      if (got_q.size() > q0 + i) begin
        total++; if (got_q[q0 + i] !== bytes[i]) begin bad++; $display("FAIL b2b_byte%0d got=%h want=%h", i, got_q[q0 + i], bytes[i]); end
      end
    end
    total++; if ({rx_data, data_ready, overrun} !== {m_data, m_ready, m_ovr}) begin bad++; $display("FAIL b2b_state got=%h%b%b want=%h%b%b", rx_data, data_ready, overrun, m_data, m_ready, m_ovr); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 5; n++) begin
      logic [7:0] b;
      int mode, v0;
      b = 8'($urandom);
      mode = $urandom_range(0, 2);
      v0 = valid_cnt;
      wait_cycles($urandom_range(1, 50));
      if (mode == 1) pulse_read();
      if (mode != 0) m_read();
      send_frame(b, 1'b1, c_bit, mode == 2);
      rx = 1'b1; wait_cycles(5);
      m_good(b);
      total++; if (valid_cnt - v0 !== 1) begin bad++; $display("FAIL rand%0d_valid got=%0d want=1", n, valid_cnt - v0); end
      total++; if ({rx_data, data_ready, overrun} !== {m_data, m_ready, m_ovr}) begin bad++; $display("FAIL rand%0d_state mode=%0d got=%h%b%b want=%h%b%b", n, mode, rx_data, data_ready, overrun, m_data, m_ready, m_ovr); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_mid_reset();
    test_back_to_back();
    test_random();
    total++; if (both_cnt !== 0) begin bad++; $display("FAIL valid_ferr_exclusive got=%0d want=0", both_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
